hdmi_video_timing_ctrl: RTL and testbench

//  Sequencer for the HDMI/DVI transmitter: generates the raster (hsync, vsync, de) for
//  the video_* inputs of the TMDS encoder/serializer path, requests pixels from an upstream

---
 rtl/hdmi_video_timing_ctrl.sv | 156 +++++++++++++++
 tb/tb_hdmi_video_timing_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing_ctrl.sv
// HDMI/DVI raster sequencer: generates hsync/vsync/de, requests pixels from an upstream
// source and aligns the returned RGB888 data with the timing after RD_LATENCY cycles.
module hdmi_video_timing_ctrl #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit SYNC_POL   = 1'b1,
  parameter int RD_LATENCY = 2
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        video_en,
  input  logic        underflow_clr,
  output logic        pixel_req,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  input  logic        pixel_valid,
  input  logic [23:0] pixel_data,
  output logic [23:0] video_din,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic        frame_start,
  output logic        busy,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_W   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS_W    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE_W    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST_W  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_W   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS_W    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE_W    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST_W  = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state;
  state_t      next_state;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        running;
  logic        frame_wrap;
  logic        act;
  logic        hs;
  logic        vs;
  logic        fs;

  logic [RD_LATENCY-1:0] act_pipe;
  logic [RD_LATENCY-1:0] hs_pipe;
  logic [RD_LATENCY-1:0] vs_pipe;
  logic [RD_LATENCY-1:0] fs_pipe;
  logic                  act_d;

  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Stopping takes effect only at the frame wrap so the sink never sees a truncated frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (video_en) next_state = RUN;
      RUN: begin
        if (!video_en) next_state = frame_wrap ? IDLE : STOP;
      end
      STOP: begin
        if (video_en)        next_state = RUN;
        else if (frame_wrap) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running = (state != IDLE);
    busy    = running;
  end

  assign frame_wrap = (h_cnt == H_LAST_W) && (v_cnt == V_LAST_W);

  always_ff @(posedge pclk) begin
    if (reset || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_W) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_W) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_comb begin
    act       = running && (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
    hs        = running && (h_cnt >= H_SS_W) && (h_cnt < H_SE_W);
    vs        = running && (v_cnt >= V_SS_W) && (v_cnt < V_SE_W);
    fs        = running && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    pixel_req = act;
    pixel_x   = act ? h_cnt : 11'd0;
    pixel_y   = act ? v_cnt : 11'd0;
  end

  // Timing flags travel alongside the source read so they meet pixel_data in the same cycle.
  always_ff @(posedge pclk) begin
    if (reset) begin
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      fs_pipe  <= '0;
    end else begin
      act_pipe[0] <= act;
      hs_pipe[0]  <= hs;
      vs_pipe[0]  <= vs;
      fs_pipe[0]  <= fs;
      for (int i = 1; i < RD_LATENCY; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        fs_pipe[i]  <= fs_pipe[i-1];
      end
    end
  end

  assign act_d = act_pipe[RD_LATENCY-1];

  always_ff @(posedge pclk) begin
    if (reset) begin
      video_din   <= '0;
      video_de    <= 1'b0;
      video_hsync <= ~SYNC_POL;
      video_vsync <= ~SYNC_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      video_din   <= (act_d && pixel_valid) ? pixel_data : 24'h0;
      video_de    <= act_d;
      video_hsync <= hs_pipe[RD_LATENCY-1] ^ ~SYNC_POL;
      video_vsync <= vs_pipe[RD_LATENCY-1] ^ ~SYNC_POL;
      frame_start <= fs_pipe[RD_LATENCY-1];
      if (underflow_clr)              underflow <= 1'b0;
      else if (act_d && !pixel_valid) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Directed bench for hdmi_video_timing_ctrl on a tiny 8x6 raster with an echoing pixel source.
module tb_hdmi_video_timing_ctrl;

  logic        pclk = 1'b0;
  logic        reset;
  logic        video_en;
  logic        underflow_clr;
  logic        pixel_req;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [23:0] video_din;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_de;
  logic        frame_start;
  logic        busy;
  logic        underflow;

  logic        n_req;
  logic [10:0] n_x;
  logic [10:0] n_y;
  logic [23:0] n_din;
  logic        n_hsync;
  logic        n_vsync;
  logic        n_de;
  logic        n_fs;
  logic        n_busy;
  logic        n_underflow;

  logic        req_d1 = 1'b0, req_d2 = 1'b0;
  logic [10:0] x_d1 = '0, x_d2 = '0, y_d1 = '0, y_d2 = '0;
  logic        drop_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .RD_LATENCY(2)
  ) dut (
    .pclk(pclk), .reset(reset), .video_en(video_en), .underflow_clr(underflow_clr),
    .pixel_req(pixel_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .video_din(video_din),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de),
    .frame_start(frame_start), .busy(busy), .underflow(underflow)
  );

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .RD_LATENCY(2)
  ) dut_n (
    .pclk(pclk), .reset(reset), .video_en(video_en), .underflow_clr(underflow_clr),
    .pixel_req(n_req), .pixel_x(n_x), .pixel_y(n_y),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .video_din(n_din),
    .video_hsync(n_hsync), .video_vsync(n_vsync), .video_de(n_de),
    .frame_start(n_fs), .busy(n_busy), .underflow(n_underflow)
  );

  always #5 pclk = ~pclk;

  // Pixel source: echoes the requested coordinates two cycles later.
  always @(posedge pclk) begin
    req_d1 <= pixel_req;
    x_d1   <= pixel_x;
    y_d1   <= pixel_y;
    req_d2 <= req_d1;
    x_d2   <= x_d1;
    y_d2   <= y_d1;
  end

  assign pixel_valid = req_d2 & ~drop_valid;
  assign pixel_data  = {2'b00, x_d2, y_d2};

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  function automatic void model(input int k, output logic act, output logic hs,
                                output logic vs, output logic fs,
                                output logic [10:0] x, output logic [10:0] y);
    int h;
    int v;
    act = 1'b0; hs = 1'b0; vs = 1'b0; fs = 1'b0; x = '0; y = '0;
    if (k >= 0) begin
      h   = k % 8;
      v   = (k / 8) % 6;
      act = (h < 4) && (v < 3);
      hs  = (h >= 5) && (h < 7);
      vs  = (v == 4);
      fs  = (h == 0) && (v == 0);
      x   = act ? 11'(h) : 11'd0;
      y   = act ? 11'(v) : 11'd0;
    end
  endfunction

  // Leaves the DUT running with cyc = 0 on the cycle whose counters are (0,0).
  task automatic start_run();
    reset = 1'b1; video_en = 1'b0; underflow_clr = 1'b0; drop_valid = 1'b0;
    tick(); tick();
    reset = 1'b0; video_en = 1'b1;
    tick();
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; video_en = 1'b1; underflow_clr = 1'b0; drop_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({video_din, video_de, video_hsync, video_vsync, pixel_req, pixel_x, pixel_y,
         frame_start, busy, underflow} !== 56'h0) begin
      errors++;
      $display("FAIL reset_outputs got din=%h de=%b hs=%b vs=%b req=%b x=%0d y=%0d fs=%b busy=%b uf=%b want all zero",
               video_din, video_de, video_hsync, video_vsync, pixel_req, pixel_x, pixel_y,
               frame_start, busy, underflow);
    end
    checks++;
    if ({n_hsync, n_vsync} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync_low_pol got %b%b want 11", n_hsync, n_vsync);
    end
  endtask

  task automatic test_raster();
    logic act, hs, vs, fs, oact, ohs, ovs, ofs;
    logic [10:0] x, y, ox, oy;
    logic [23:0] exp_din;
    start_run();
    for (int n = 0; n < 102; n++) begin
      model(n, act, hs, vs, fs, x, y);
      model(n - 3, oact, ohs, ovs, ofs, ox, oy);
      exp_din = oact ? {2'b00, ox, oy} : 24'h0;
      checks++;
      if ({pixel_req, pixel_x, pixel_y, busy} !== {act, x, y, 1'b1}) begin
        errors++;
        $display("FAIL raster_req n=%0d got req=%b x=%0d y=%0d busy=%b want req=%b x=%0d y=%0d busy=1",
                 n, pixel_req, pixel_x, pixel_y, busy, act, x, y);
      end
      checks++;
      if ({video_de, video_din, frame_start} !== {oact, exp_din, ofs}) begin
        errors++;
        $display("FAIL raster_data n=%0d got de=%b din=%h fs=%b want de=%b din=%h fs=%b",
                 n, video_de, video_din, frame_start, oact, exp_din, ofs);
      end
      checks++;
      if ({video_hsync, video_vsync, n_hsync, n_vsync} !== {ohs, ovs, ~ohs, ~ovs}) begin
        errors++;
        $display("FAIL raster_sync n=%0d got hs=%b vs=%b hs_n=%b vs_n=%b want hs=%b vs=%b hs_n=%b vs_n=%b",
                 n, video_hsync, video_vsync, n_hsync, n_vsync, ohs, ovs, ~ohs, ~ovs);
      end
      checks++;
      if (underflow !== 1'b0) begin
        errors++;
        $display("FAIL raster_underflow n=%0d got %b want 0", n, underflow);
      end
      tick();
    end
  endtask

  task automatic test_stop();
    start_run();
    while (cyc < 10) tick();
    video_en = 1'b0;
    while (cyc < 16) tick();
    checks++;
    if ({pixel_req, busy} !== 2'b11) begin
      errors++;
      $display("FAIL stop_still_running got req=%b busy=%b want 1 1", pixel_req, busy);
    end
    while (cyc < 47) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_busy_last got %b want 1", busy);
    end
    tick();
    checks++;
    if ({busy, pixel_req, video_hsync, video_de} !== 4'b0010) begin
      errors++;
      $display("FAIL stop_wrap got busy=%b req=%b hs=%b de=%b want 0 0 1 0",
               busy, pixel_req, video_hsync, video_de);
    end
    tick(); tick();
    checks++;
    if (video_hsync !== 1'b0) begin
      errors++;
      $display("FAIL stop_tail_hs got %b want 0", video_hsync);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({busy, pixel_req, video_de, frame_start} !== 4'b0000) begin
        errors++;
        $display("FAIL stop_idle i=%0d got busy=%b req=%b de=%b fs=%b want 0 0 0 0",
                 i, busy, pixel_req, video_de, frame_start);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    start_run();
    while (cyc < 10) tick();
    video_en = 1'b0;
    while (cyc < 30) tick();
    video_en = 1'b1;
    while (cyc < 48) tick();
    checks++;
    if ({busy, pixel_req, pixel_x, pixel_y} !== {1'b1, 1'b1, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL restart_req got busy=%b req=%b x=%0d y=%0d want 1 1 0 0",
               busy, pixel_req, pixel_x, pixel_y);
    end
    while (cyc < 51) tick();
    checks++;
    if ({video_de, frame_start, video_din} !== {1'b1, 1'b1, 24'h0}) begin
      errors++;
      $display("FAIL restart_out got de=%b fs=%b din=%h want 1 1 000000",
               video_de, frame_start, video_din);
    end
  endtask

  task automatic test_underflow();
    start_run();
    while (cyc < 11) tick();
    drop_valid = 1'b1;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_before got %b want 0", underflow);
    end
    tick();
    drop_valid = 1'b0;
    checks++;
    if ({video_de, video_din, underflow} !== {1'b1, 24'h0, 1'b1}) begin
      errors++;
      $display("FAIL uf_set got de=%b din=%h uf=%b want 1 000000 1", video_de, video_din, underflow);
    end
    tick();
    checks++;
    if ({video_din, underflow} !== {2'b00, 11'd2, 11'd1, 1'b1}) begin
      errors++;
      $display("FAIL uf_sticky got din=%h uf=%b want %h 1", video_din, underflow,
               {2'b00, 11'd2, 11'd1});
    end
    while (cyc < 14) tick();
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear got %b want 0", underflow);
    end
    while (cyc < 19) tick();
    drop_valid = 1'b1;
    underflow_clr = 1'b1;
    tick();
    drop_valid = 1'b0;
    underflow_clr = 1'b0;
    checks++;
    if ({video_de, video_din, underflow} !== {1'b1, 24'h0, 1'b0}) begin
      errors++;
      $display("FAIL uf_clr_wins got de=%b din=%h uf=%b want 1 000000 0", video_de, video_din, underflow);
    end
    tick();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_after_clr got %b want 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    start_run();
    while (cyc < 9) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({video_din, video_de, video_hsync, video_vsync, pixel_req, pixel_x, pixel_y,
         frame_start, busy, underflow, n_hsync, n_vsync} !== {54'h0, 2'b11}) begin
      errors++;
      $display("FAIL mid_reset got din=%h de=%b hs=%b vs=%b req=%b x=%0d y=%0d fs=%b busy=%b uf=%b hsn=%b vsn=%b want zeros, hsn=vsn=1",
               video_din, video_de, video_hsync, video_vsync, pixel_req, pixel_x, pixel_y,
               frame_start, busy, underflow, n_hsync, n_vsync);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({pixel_req, pixel_x, pixel_y, busy} !== {1'b1, 11'd0, 11'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_restart_req got req=%b x=%0d y=%0d busy=%b want 1 0 0 1",
               pixel_req, pixel_x, pixel_y, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({video_de, video_din, frame_start, underflow} !== 27'h0) begin
        errors++;
        $display("FAIL mid_no_stale i=%0d got de=%b din=%h fs=%b uf=%b want all 0",
                 i, video_de, video_din, frame_start, underflow);
      end
      tick();
    end
    checks++;
    if ({video_de, frame_start, video_din} !== {1'b1, 1'b1, 24'h0}) begin
      errors++;
      $display("FAIL mid_first_pixel got de=%b fs=%b din=%h want 1 1 000000",
               video_de, frame_start, video_din);
    end
    tick();
    checks++;
    if ({video_de, frame_start, video_din} !== {1'b1, 1'b0, 2'b00, 11'd1, 11'd0}) begin
      errors++;
      $display("FAIL mid_second_pixel got de=%b fs=%b din=%h want 1 0 %h",
               video_de, frame_start, video_din, {2'b00, 11'd1, 11'd0});
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_stop();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
